spinn_aer_cmd_pkt_tx: RTL and testbench
=======================================

# spinn_aer_cmd_pkt_tx

Command-packet transmitter for the SpiNNaker↔AER interface: the initiator side of the go/stop control channel. Local start/stop requests become 72-bit SpiNNaker multicast packets with key bit 0 carrying the go value, and leave through a valid/ready handshake toward the SpiNNaker link transmitter. An optional periodic refresh re-sends the current go state. The receiver-side control block at the far end decodes `go` from packet bit 8.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 1000000: idle cycles between refresh packets (with `CMD_REFRESH_EN` only); legal range 2 to 2^24-1.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle request: go=1
- `stop`  in  1  single-cycle request: go=0
- `cmd_key`  in  `VKEY_BITS` (32)  command key base; bit 0 ignored
- `cpkt_data`  out  `PKT_BITS` (72)  packet, registered
- `cpkt_vld`  out  1  packet valid, registered
- `cpkt_rdy`  in  1  downstream ready
- `go_tx`  out  1  go value of the most recently accepted packet
- `busy`  out  1  high while `cpkt_vld` is high or a request is pending

## Operation
- Packet format: [71:40] payload=0; [39:8] key = {`cmd_key[31:1]`, go}; [7:6]=2'b00 (MC); [5:2]=0; [1]=0 (no payload); [0] = parity chosen so that XOR of [71:0] is 1 (odd parity).
- Request resolution per cycle: `stop` wins when `start` and `stop` are both asserted. The requested value is `req_go`.
- FSM states:
  - IDLE: `cpkt_vld`=0. On a request, form the packet from `req_go` and `cmd_key` sampled that cycle, then go to SEND. On refresh expiry, form the packet from `go_tx` and go to SEND.
  - SEND: `cpkt_vld`=1 and `cpkt_data` held stable until the cycle where `cpkt_vld & cpkt_rdy`. At acceptance, `go_tx` takes the packet's go bit. If a request is pending, reload `cpkt_data` with the pending value, clear pending, and stay in SEND. Otherwise go to IDLE.
- Pending register: one entry (valid flag plus go value). A request made during SEND, including in the acceptance cycle, sets pending. A later request overwrites it; only the latest value is kept.
- The refresh counter clears on every acceptance and on reset. It counts only in IDLE with nothing pending. Expiry occurs when the count reaches `REFRESH_CYCLES-1`.
- A request always takes priority over a refresh in the same cycle.

## Timing
- Reset values: `cpkt_vld`=0, `cpkt_data`=0, `go_tx`=`INIT_GO`, `busy`=0, pending cleared, counter 0.
- Reset asserted mid-SEND drops the packet immediately (asynchronous). No retransmission after reset.
- Latency: a request in cycle N gives `cpkt_vld`=1 in cycle N+1.
- Back-to-back: with `cpkt_rdy` held high, a pending packet is presented the cycle after acceptance, so throughput is 1 packet/cycle.
- `go_tx` updates the cycle after acceptance.

## Configuration
- `CMD_REFRESH_EN` defined: the refresh counter is present and `REFRESH_CYCLES` is honoured.
- `CMD_REFRESH_EN` undefined: no counter; packets are sent only on requests. `REFRESH_CYCLES` is ignored.

## Structure
- Shared header/package holds: `PKT_BITS`, `VKEY_BITS`, `INIT_GO`, packet field bit positions, packet-type constant MC=2'b00, and FSM state encodings.
- One sub-module, `spinn_pkt_parity`: combinational, 71-bit input, outputs the odd-parity bit. It is reusable by other packet sources.

## Test plan
- Reset, then `start` with `cmd_key`=0x12340000 and `cpkt_rdy`=1 → one packet with key 0x12340001 and parity correct (XOR of [71:0]=1). `go_tx`=1 afterwards.
- `cpkt_rdy`=0 for 10 cycles after `start` → `cpkt_vld` and `cpkt_data` stable for all 10 cycles. Exactly one packet accepted when `cpkt_rdy` rises.
- During a stalled SEND, pulse `stop` then `start` → after the first acceptance, exactly one further packet, with go=1.
- `start` and `stop` asserted in the same cycle → packet key bit 0 = 0.
- With `CMD_REFRESH_EN` and `REFRESH_CYCLES`=16, idle after `go_tx`=1 → a refresh packet (go=1) every 17 cycles with `cpkt_rdy`=1. Without the macro → no packets.
- Assert `rst` while `cpkt_vld`=1 → `cpkt_vld`=0 immediately, `go_tx`=`INIT_GO`, and no packet after reset release.

Source files
------------

// File: rtl/spinn_aer_cmd_pkt_tx_pkg.sv
// Shared definitions for SpiNNaker command-packet sources.
// Holds packet/key widths, the reset go value, multicast packet field
// positions, the MC packet-type code and the transmitter FSM states.
package spinn_aer_cmd_pkt_tx_pkg;

  localparam int unsigned PKT_BITS  = 72;
  localparam int unsigned VKEY_BITS = 32;
  localparam logic        INIT_GO   = 1'b0;

  // Multicast packet field positions
  localparam int unsigned PAY_MSB  = 71;
  localparam int unsigned PAY_LSB  = 40;
  localparam int unsigned KEY_MSB  = 39;
  localparam int unsigned KEY_LSB  = 8;
  localparam int unsigned TYPE_MSB = 7;
  localparam int unsigned TYPE_LSB = 6;
  localparam int unsigned PL_BIT   = 1;
  localparam int unsigned PAR_BIT  = 0;

  localparam logic [1:0] PKT_MC = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } cmd_tx_state_t;

endpackage

// File: rtl/spinn_pkt_parity.sv
// Odd-parity generator for SpiNNaker packets.
// data_i : packet bits [71:1]
// par_o  : bit 0 value that makes the XOR of all 72 bits equal 1
module spinn_pkt_parity (
  input  logic [70:0] data_i,
  output logic        par_o
);

  assign par_o = ~(^data_i);

endmodule

// File: rtl/spinn_aer_cmd_pkt_tx.sv
// Go/stop command-packet transmitter (initiator side of the control channel).
// start/stop requests become multicast packets whose key bit 0 carries go;
// packets leave through a cpkt_vld/cpkt_rdy handshake.
// Ports: clk, rst (async, active-high), start, stop, cmd_key[31:0],
//        cpkt_data[71:0], cpkt_vld, cpkt_rdy, go_tx, busy.
// Build option: CMD_REFRESH_EN adds a periodic refresh of the current go
// state after REFRESH_CYCLES idle cycles.
module spinn_aer_cmd_pkt_tx
  import spinn_aer_cmd_pkt_tx_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [VKEY_BITS-1:0] cmd_key,
  output logic [PKT_BITS-1:0]  cpkt_data,
  output logic                 cpkt_vld,
  input  logic                 cpkt_rdy,
  output logic                 go_tx,
  output logic                 busy
);

  localparam logic [23:0] REFRESH_LAST = 24'(REFRESH_CYCLES - 1);

  cmd_tx_state_t         state_q, state_d;
  logic [PKT_BITS-1:0]   data_q, data_d;
  logic                  go_q, go_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_go_q, pend_go_d;

  logic                  req, req_go, load_go, par, refresh_due;
  logic [PKT_BITS-1:1]   pkt_body;
  logic                  unused_key0;

  assign req         = start | stop;
  assign req_go      = ~stop;
  assign unused_key0 = cmd_key[0];

  // go value for whichever packet may be loaded this cycle
  always_comb begin
    if (state_q == ST_SEND && pend_vld_q) load_go = pend_go_q;
    else if (req)                         load_go = req_go;
    else                                  load_go = go_q;
  end

  always_comb begin
    pkt_body                    = '0;
    pkt_body[KEY_MSB:KEY_LSB+1] = cmd_key[VKEY_BITS-1:1];
    pkt_body[KEY_LSB]           = load_go;
    pkt_body[TYPE_MSB:TYPE_LSB] = PKT_MC;
    pkt_body[PL_BIT]            = 1'b0;
  end

  spinn_pkt_parity u_parity (
    .data_i (pkt_body),
    .par_o  (par)
  );

`ifdef CMD_REFRESH_EN
  logic [23:0] cnt_q, cnt_d;

  assign refresh_due = (state_q == ST_IDLE) && !pend_vld_q && (cnt_q == REFRESH_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SEND && cpkt_rdy)
      cnt_d = '0;
    else if (state_q == ST_IDLE && !pend_vld_q && !req && !refresh_due)
      cnt_d = cnt_q + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_refresh;
  assign unused_refresh = ^REFRESH_LAST;
  assign refresh_due    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    go_d       = go_q;
    pend_vld_d = pend_vld_q;
    pend_go_d  = pend_go_q;
    case (state_q)
      ST_IDLE: begin
        if (req || refresh_due) begin
          data_d  = {pkt_body, par};
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cpkt_rdy) begin
          go_d = data_q[KEY_LSB];
          // A request in the acceptance cycle with nothing pending is loaded
          // straight away; this is what passing through pending would yield.
          if (pend_vld_q) begin
            data_d     = {pkt_body, par};
            pend_vld_d = req;
            pend_go_d  = req ? req_go : pend_go_q;
          end else if (req) begin
            data_d = {pkt_body, par};
          end else begin
            state_d = ST_IDLE;
          end
        end else if (req) begin
          pend_vld_d = 1'b1;
          pend_go_d  = req_go;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      go_q       <= INIT_GO;
      pend_vld_q <= 1'b0;
      pend_go_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      go_q       <= go_d;
      pend_vld_q <= pend_vld_d;
      pend_go_q  <= pend_go_d;
    end
  end

  assign cpkt_vld  = (state_q == ST_SEND);
  assign cpkt_data = data_q;
  assign go_tx     = go_q;
  assign busy      = cpkt_vld | pend_vld_q;

endmodule

// File: tb/tb_spinn_aer_cmd_pkt_tx.sv
module tb_spinn_aer_cmd_pkt_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, cpkt_rdy = 1'b0;
  logic [31:0] cmd_key = '0;
  logic [71:0] cpkt_data;
  logic        cpkt_vld, go_tx, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int acc_cyc[$];
  logic [71:0] last_acc_data = '0;

  spinn_aer_cmd_pkt_tx #(.REFRESH_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cmd_key   (cmd_key),
    .cpkt_data (cpkt_data),
    .cpkt_vld  (cpkt_vld),
    .cpkt_rdy  (cpkt_rdy),
    .go_tx     (go_tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cpkt_vld && cpkt_rdy) begin
      acc <= acc + 1;
      acc_cyc.push_back(cyc);
      last_acc_data <= cpkt_data;
    end
  end

  typedef struct {
    logic        start, stop, rdy;
    logic [31:0] key;
    logic        vld;
    logic [71:0] data;
    logic        go;
    logic        busy;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [71:0] pk(input logic [31:0] key, input logic go);
    logic [71:0] p;
    p = '0;
    p[39:8] = {key[31:1], go};
    p[0] = 1'b1;
    for (int i = 1; i < 72; i++) p[0] = p[0] ^ p[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int a0, base, n0, waited;
    logic [71:0] snap;

    vecs[0]  = '{1, 0, 1, 32'h12340000, 1, 72'h12_3400_0101,          0, 1};
    vecs[1]  = '{0, 0, 1, 32'h12340000, 0, 72'h12_3400_0101,          1, 0};
    vecs[2]  = '{0, 0, 1, 32'h12340000, 0, 72'h12_3400_0101,          1, 0};
    vecs[3]  = '{0, 1, 0, 32'hA5A50000, 1, pk(32'hA5A50000, 0),       1, 1};
    vecs[4]  = '{0, 0, 0, 32'hA5A50000, 1, pk(32'hA5A50000, 0),       1, 1};
    vecs[5]  = '{1, 0, 0, 32'hA5A50000, 1, pk(32'hA5A50000, 0),       1, 1};
    vecs[6]  = '{0, 0, 1, 32'hA5A50000, 1, pk(32'hA5A50000, 1),       0, 1};
    vecs[7]  = '{0, 0, 1, 32'hA5A50000, 0, pk(32'hA5A50000, 1),       1, 0};
    vecs[8]  = '{1, 1, 1, 32'h0000FFFE, 1, pk(32'h0000FFFE, 0),       1, 1};
    vecs[9]  = '{1, 0, 1, 32'h0000FFFE, 1, pk(32'h0000FFFE, 1),       0, 1};
    vecs[10] = '{0, 1, 1, 32'h0000FFFE, 1, pk(32'h0000FFFE, 0),       1, 1};
    vecs[11] = '{0, 0, 1, 32'h0000FFFE, 0, pk(32'h0000FFFE, 0),       0, 0};
    vecs[12] = '{0, 1, 0, 32'hFFFFFFFF, 1, pk(32'hFFFFFFFF, 0),       0, 1};
    vecs[13] = '{0, 0, 1, 32'hFFFFFFFF, 0, pk(32'hFFFFFFFF, 0),       0, 0};

    // Reset state
    #12;
    chk("rst_vld", {71'b0, cpkt_vld}, 72'd0);
    chk("rst_data", cpkt_data, 72'd0);
    chk("rst_go", {71'b0, go_tx}, 72'd0);
    chk("rst_busy", {71'b0, busy}, 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      cpkt_rdy = vecs[i].rdy; cmd_key = vecs[i].key;
      tick();
      chk($sformatf("v%0d_vld", i), {71'b0, cpkt_vld}, {71'b0, vecs[i].vld});
      chk($sformatf("v%0d_data", i), cpkt_data, vecs[i].data);
      chk($sformatf("v%0d_go", i), {71'b0, go_tx}, {71'b0, vecs[i].go});
      chk($sformatf("v%0d_busy", i), {71'b0, busy}, {71'b0, vecs[i].busy});
      if (cpkt_vld) chk($sformatf("v%0d_par", i), {71'b0, ^cpkt_data}, 72'd1);
    end
    start = 0; stop = 0;

    // Stall for 10 cycles: packet held stable, exactly one acceptance
    cmd_key = 32'h0BAD0000; start = 1; cpkt_rdy = 0;
    tick();
    start = 0;
    snap = cpkt_data;
    chk("stall_data0", snap, pk(32'h0BAD0000, 1));
    a0 = acc;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall%0d_vld", i), {71'b0, cpkt_vld}, 72'd1);
      chk($sformatf("stall%0d_data", i), cpkt_data, snap);
    end
    cpkt_rdy = 1;
    tick();
    chk("stall_release_vld", {71'b0, cpkt_vld}, 72'd0);
    tick(); tick();
    chk("stall_acc_count", 72'(acc - a0), 72'd1);
    chk("stall_go", {71'b0, go_tx}, 72'd1);
    base = acc_cyc[acc_cyc.size() - 1];

`ifdef CMD_REFRESH_EN
    n0 = acc_cyc.size();
    waited = 0;
    while (acc_cyc.size() < n0 + 3 && waited < 100) begin
      tick();
      waited++;
    end
    if (acc_cyc.size() < n0 + 3) begin
      chk("refresh_timeout", 72'(acc_cyc.size() - n0), 72'd3);
    end else begin
      chk("refresh_gap0", 72'(acc_cyc[n0] - base), 72'd17);
      chk("refresh_gap1", 72'(acc_cyc[n0 + 1] - acc_cyc[n0]), 72'd17);
      chk("refresh_gap2", 72'(acc_cyc[n0 + 2] - acc_cyc[n0 + 1]), 72'd17);
      chk("refresh_go", {71'b0, last_acc_data[8]}, 72'd1);
    end
`else
    n0 = acc;
    waited = base;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpkt_vld) waited = -1;
    end
    chk("norefresh_acc", 72'(acc - n0), 72'd0);
    chk("norefresh_vld", 72'(waited == -1), 72'd0);
`endif

    // Reset during SEND drops the packet asynchronously
    cpkt_rdy = 0; start = 1; cmd_key = 32'h55550000;
    tick();
    start = 0;
    chk("rstsend_pre_vld", {71'b0, cpkt_vld}, 72'd1);
    #2 rst = 1;
    #1;
    chk("rstsend_vld", {71'b0, cpkt_vld}, 72'd0);
    chk("rstsend_go", {71'b0, go_tx}, 72'd0);
    chk("rstsend_busy", {71'b0, busy}, 72'd0);
    chk("rstsend_data", cpkt_data, 72'd0);
    @(posedge clk); #1;
    rst = 0;
    cpkt_rdy = 1;
    a0 = acc;
    for (int i = 0; i < 10; i++) tick();
    chk("rstsend_no_pkt", 72'(acc - a0), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
